// File: rtl/letter_streamer_pkg.sv
// Shared types and constants for the letter streaming path.
package letter_pkg;

  localparam int unsigned LETTER_W        = 8;
  localparam int unsigned IDX_W           = 4;
  localparam int unsigned CNT_W           = 5;
  localparam int unsigned NUM_LETTERS_DEF = 10;

  localparam logic [LETTER_W-1:0] TERM_CODE_DEF = 8'h00;
  localparam logic [LETTER_W-1:0] ASCII_TAB     = 8'h09;
  localparam logic [LETTER_W-1:0] ASCII_SPACE   = 8'h20;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD   = 2'd1,
    ST_STREAM = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

endpackage

// File: rtl/letter_streamer_if.sv
// Valid/ready letter stream: one ASCII letter plus its slot index per transfer.
interface letter_streamer_if;
  import letter_pkg::*;

  logic [LETTER_W-1:0] ascii_out;
  logic                out_valid;
  logic                out_ready;
  logic [IDX_W-1:0]    index;

  modport master (output ascii_out, output out_valid, output index, input out_ready);
  modport slave  (input ascii_out, input out_valid, input index, output out_ready);

endinterface

// File: rtl/letter_streamer_snapshot.sv
// Captured copy of the letter bank with an indexed read port.
module letter_snapshot
  import letter_pkg::*;
#(
  parameter int unsigned NUM_LETTERS = NUM_LETTERS_DEF
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            capture,
  input  logic [LETTER_W*NUM_LETTERS-1:0] letters_in,
  input  logic [IDX_W-1:0]                rd_idx,
  output logic [LETTER_W-1:0]             rd_data_c
);

  logic [LETTER_W-1:0] bank [NUM_LETTERS];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < NUM_LETTERS; k++) bank[k] <= '0;
    end else if (capture) begin
      for (int k = 0; k < NUM_LETTERS; k++) bank[k] <= letters_in[k*LETTER_W +: LETTER_W];
    end
  end

  // Slots past the end of the word read as zero.
  always_comb begin
    rd_data_c = '0;
    if (32'(rd_idx) < NUM_LETTERS) rd_data_c = bank[rd_idx];
  end

endmodule

// File: rtl/letter_streamer.sv
// Streams a snapshot of the letter bank one letter per valid/ready transfer.
module letter_streamer
  import letter_pkg::*;
#(
  parameter int unsigned         NUM_LETTERS  = NUM_LETTERS_DEF,
  parameter logic [LETTER_W-1:0] TERM_CODE    = TERM_CODE_DEF,
  parameter bit                  STOP_ON_TERM = 1'b1
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            start,
  input  logic [LETTER_W*NUM_LETTERS-1:0] letters_in,
  letter_streamer_if.master               bus,
  output logic                            busy,
  output logic                            done,
  output logic [CNT_W-1:0]                sent_count
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_LETTERS - 1);

  state_t              state, state_next;
  logic                capture, transfer, at_term, at_last;
  logic [IDX_W-1:0]    rd_idx, index_d;
  logic [LETTER_W-1:0] rd_data_c, ascii_d;
  logic [CNT_W-1:0]    count_d;
  logic                valid_d, busy_d, done_d;

  letter_snapshot #(.NUM_LETTERS(NUM_LETTERS)) u_snapshot (
    .clk        (clk),
    .reset      (reset),
    .capture    (capture),
    .letters_in (letters_in),
    .rd_idx     (rd_idx),
    .rd_data_c  (rd_data_c)
  );

  // While streaming, the read port looks one slot ahead for the next letter / terminator.
  assign capture  = (state == ST_IDLE) && start;
  assign transfer = bus.out_valid && bus.out_ready;
  assign rd_idx   = (state == ST_STREAM) ? bus.index + IDX_W'(1) : '0;
  assign at_term  = STOP_ON_TERM && (rd_data_c == TERM_CODE);
  assign at_last  = (bus.index == LAST_IDX) || at_term;

  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:   if (start) state_next = ST_LOAD;
      ST_LOAD:   state_next = at_term ? ST_DONE : ST_STREAM;
      ST_STREAM: if (transfer && at_last) state_next = ST_DONE;
      ST_DONE:   state_next = ST_IDLE;
      default:   state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    index_d = bus.index;
    ascii_d = bus.ascii_out;
    count_d = sent_count;
    valid_d = (state_next == ST_STREAM);
    busy_d  = (state_next == ST_LOAD) || (state_next == ST_STREAM);
    done_d  = (state_next == ST_DONE);
    case (state)
      ST_IDLE: begin
        if (start) begin
          index_d = '0;
          count_d = '0;
        end
      end
      ST_LOAD: begin
        index_d = '0;
        ascii_d = rd_data_c;
      end
      ST_STREAM: begin
        if (transfer) begin
          count_d = sent_count + CNT_W'(1);
          if (!at_last) begin
            index_d = bus.index + IDX_W'(1);
            ascii_d = rd_data_c;
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      bus.ascii_out <= '0;
      bus.out_valid <= 1'b0;
      bus.index     <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      sent_count    <= '0;
    end else begin
      bus.ascii_out <= ascii_d;
      bus.out_valid <= valid_d;
      bus.index     <= index_d;
      busy          <= busy_d;
      done          <= done_d;
      sent_count    <= count_d;
    end
  end

endmodule
